// File: rtl/dm_access_ctrl_pkg.sv
// Shared definitions for the M-stage data-memory access controller:
// load-select codes, FSM state encoding and the store lane-replication helper.
package dm_access_ctrl_pkg;

  // Load-select codes driven by the decoder on ld_sel
  localparam logic [2:0] LD_W  = 3'd0;
  localparam logic [2:0] LD_H  = 3'd1;
  localparam logic [2:0] LD_HU = 3'd2;
  localparam logic [2:0] LD_B  = 3'd3;
  localparam logic [2:0] LD_BU = 3'd4;

  typedef enum logic [1:0] {
    DMA_IDLE = 2'd0,
    DMA_REQ  = 2'd1,
    DMA_DONE = 2'd2
  } dma_state_t;

  typedef struct packed {
    logic [3:0]  byteen;
    logic [31:0] wdata;
  } lane_t;

  // Replicate right-aligned store data into every lane the enable pattern can
  // address; patterns that are not word, aligned half or single byte are
  // turned into a write with no lanes enabled so the access still completes.
  function automatic lane_t store_lanes(input logic [3:0] be, input logic [31:0] wd);
    lane_t l;
    l.byteen = be;
    l.wdata  = wd;
    case (be)
      4'b1111:                            l.wdata = wd;
      4'b0011, 4'b1100:                   l.wdata = {2{wd[15:0]}};
      4'b0001, 4'b0010, 4'b0100, 4'b1000: l.wdata = {4{wd[7:0]}};
      default: begin
        l.byteen = 4'b0000;
        l.wdata  = 32'h0000_0000;
      end
    endcase
    return l;
  endfunction

endpackage

// File: rtl/dm_ext.sv
// Combinational load extractor: picks the addressed byte/half out of the raw
// memory word and sign- or zero-extends it according to the load select.
module dm_ext
  import dm_access_ctrl_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [1:0]  off,
  input  logic [2:0]  ld_sel,
  output logic [31:0] rdata_ext
);

  logic [15:0] half_v;
  logic [7:0]  byte_v;

  // Select the addressed half and byte, then extend per load type
  always_comb begin
    half_v = off[1] ? raw[31:16] : raw[15:0];
    case (off)
      2'd0:    byte_v = raw[7:0];
      2'd1:    byte_v = raw[15:8];
      2'd2:    byte_v = raw[23:16];
      default: byte_v = raw[31:24];
    endcase
    rdata_ext = raw;
    case (ld_sel)
      LD_H:    rdata_ext = {{16{half_v[15]}}, half_v};
      LD_HU:   rdata_ext = {16'h0000, half_v};
      LD_B:    rdata_ext = {{24{byte_v[7]}}, byte_v};
      LD_BU:   rdata_ext = {24'h000000, byte_v};
      default: rdata_ext = raw;
    endcase
  end

endmodule

// File: rtl/dm_access_ctrl.sv
// M-stage data-memory access controller. Runs one load/store per instruction
// on a req/ack memory port, stalls the pipeline until it completes, and
// returns extended load data.
// Optional feature macro: DM_TIMEOUT_EN -- aborts a request after
// TIMEOUT_CYCLES cycles without mem_ack and pulses err.
module dm_access_ctrl
  import dm_access_ctrl_pkg::*;
`ifdef DM_TIMEOUT_EN
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
)
`endif
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [3:0]  byteen,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  ld_sel,
  output logic        stall,
  output logic        rdata_valid,
  output logic [31:0] rdata_ext,
  output logic        err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_byteen,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  dma_state_t  state;
  logic [1:0]  off_q;
  logic [2:0]  ld_sel_q;
  logic        accept;
  logic [31:0] ext_data;
  lane_t       lanes;

`ifdef DM_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] cnt;
`else
  assign err = 1'b0;
`endif

  // A zero-enable store is a no-op and must neither start a transaction nor stall
  assign accept = (state == DMA_IDLE) && req_valid && !(req_we && (byteen == 4'b0000));
  assign stall  = accept || (state == DMA_REQ);
  assign lanes  = store_lanes(byteen, wdata);

  dm_ext u_ext (
    .raw       (mem_rdata),
    .off       (off_q),
    .ld_sel    (ld_sel_q),
    .rdata_ext (ext_data)
  );

  // Access FSM: latch the request, hold mem_req until ack, report in DONE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= DMA_IDLE;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= 32'h0000_0000;
      mem_byteen  <= 4'b0000;
      mem_wdata   <= 32'h0000_0000;
      off_q       <= 2'd0;
      ld_sel_q    <= 3'd0;
      rdata_valid <= 1'b0;
      rdata_ext   <= 32'h0000_0000;
`ifdef DM_TIMEOUT_EN
      err         <= 1'b0;
      cnt         <= '0;
`endif
    end else begin
      rdata_valid <= 1'b0;
`ifdef DM_TIMEOUT_EN
      err         <= 1'b0;
`endif
      case (state)
        DMA_IDLE: begin
          if (accept) begin
            mem_req    <= 1'b1;
            mem_we     <= req_we;
            mem_addr   <= {addr[31:2], 2'b00};
            mem_byteen <= req_we ? lanes.byteen : 4'b1111;
            mem_wdata  <= lanes.wdata;
            off_q      <= addr[1:0];
            ld_sel_q   <= ld_sel;
`ifdef DM_TIMEOUT_EN
            cnt        <= '0;
`endif
            state      <= DMA_REQ;
          end
        end
        DMA_REQ: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (!mem_we) begin
              rdata_valid <= 1'b1;
              rdata_ext   <= ext_data;
            end
            state <= DMA_DONE;
          end
`ifdef DM_TIMEOUT_EN
          else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            mem_req     <= 1'b0;
            err         <= 1'b1;
            rdata_valid <= !mem_we;
            rdata_ext   <= 32'h0000_0000;
            state       <= DMA_DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
`endif
        end
        DMA_DONE: state <= DMA_IDLE;
        default:  state <= DMA_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Self-checking bench for dm_access_ctrl: directed scenarios plus randomized
// transactions, all checked against an arithmetic reference model.
module tb_dm_access_ctrl;
  import dm_access_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_we;
  logic [3:0]  byteen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [2:0]  ld_sel;
  logic        stall;
  logic        rdata_valid;
  logic [31:0] rdata_ext;
  logic        err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_byteen;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int compared   = 0;
  int mismatched = 0;

  logic [31:0] obs_addr;
  logic [3:0]  obs_byteen;
  logic [31:0] obs_wdata;
  logic [31:0] obs_rdata;
  int          obs_stall_cnt;

  dm_access_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_we      (req_we),
    .byteen      (byteen),
    .addr        (addr),
    .wdata       (wdata),
    .ld_sel      (ld_sel),
    .stall       (stall),
    .rdata_valid (rdata_valid),
    .rdata_ext   (rdata_ext),
    .err         (err),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_byteen  (mem_byteen),
    .mem_wdata   (mem_wdata),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata)
  );

  always #5 clk = ~clk;

  // Reference load result: shift the addressed field down, mask, extend
  function automatic logic [31:0] exp_load(input logic [2:0] ls, input logic [31:0] raw,
                                           input logic [31:0] a);
    int unsigned k;
    longint v;
    k = a % 4;
    if (ls == LD_H || ls == LD_HU) begin
      v = longint'((raw >> (16 * (k / 2))) & 32'h0000FFFF);
      if (ls == LD_H && v >= 32768) v = v - 65536;
    end else if (ls == LD_B || ls == LD_BU) begin
      v = longint'((raw >> (8 * k)) & 32'h000000FF);
      if (ls == LD_B && v >= 128) v = v - 256;
    end else begin
      v = longint'(raw);
    end
    return v[31:0];
  endfunction

  // Reference store lanes: replicate by multiplication, reject odd patterns
  task automatic exp_store(input logic [3:0] be, input logic [31:0] wd,
                           output logic [3:0] ebe, output logic [31:0] ewd, output bit chk);
    ebe = be;
    chk = 1'b1;
    if (be == 4'hF) ewd = wd;
    else if (be == 4'h3 || be == 4'hC) ewd = (wd & 32'h0000FFFF) * 32'h00010001;
    else if ($countones(be) == 1) ewd = (wd & 32'h000000FF) * 32'h01010101;
    else begin
      ebe = 4'h0;
      ewd = 32'h0;
      chk = 1'b0;
    end
  endtask

  // One complete access; ack arrives in the delay-th REQ cycle
  task automatic do_txn(input logic we, input logic [3:0] be, input logic [31:0] a,
                        input logic [31:0] wd, input logic [2:0] ls, input int delay,
                        input logic [31:0] raw, input bit ack_in_done);
    logic [3:0]  ebe;
    logic [31:0] ewd;
    logic [31:0] erd;
    bit          chk_wd;
    int          stall_cnt;
    exp_store(be, wd, ebe, ewd, chk_wd);
    if (!we) begin
      ebe = 4'hF;
      chk_wd = 1'b0;
    end
    erd = exp_load(ls, raw, a);
    stall_cnt = 0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = we; byteen = be; addr = a; wdata = wd; ld_sel = ls;
    mem_ack = 1'b0; mem_rdata = $urandom;
    @(negedge clk);
    if (stall) stall_cnt++;
    for (int c = 1; c <= delay; c++) begin
      @(posedge clk); #1;
      mem_ack = (c == delay);
      mem_rdata = (c == delay) ? raw : $urandom;
      @(negedge clk);
      if (stall) stall_cnt++;
      if (c == 1) begin
        obs_addr = mem_addr; obs_byteen = mem_byteen; obs_wdata = mem_wdata;
        compared++;
        if (mem_req !== 1'b1 || mem_we !== we || mem_addr !== {a[31:2], 2'b00} ||
            mem_byteen !== ebe || (chk_wd && mem_wdata !== ewd) || rdata_valid !== 1'b0) begin
          mismatched++;
          $display("[TB] FAIL req_fields: got req=%b we=%b addr=%h be=%b wd=%h rv=%b, want req=1 we=%b addr=%h be=%b wd=%h rv=0",
                   mem_req, mem_we, mem_addr, mem_byteen, mem_wdata, rdata_valid,
                   we, {a[31:2], 2'b00}, ebe, ewd);
        end
      end
    end
    @(posedge clk); #1;
    mem_ack = ack_in_done; mem_rdata = $urandom;
    @(negedge clk);
    obs_stall_cnt = stall_cnt;
    obs_rdata = rdata_ext;
    compared++;
    if (stall_cnt != delay + 1) begin
      mismatched++;
      $display("[TB] FAIL stall_len: got %0d cycles, want %0d", stall_cnt, delay + 1);
    end
    compared++;
    if (stall !== 1'b0 || mem_req !== 1'b0 || rdata_valid !== !we || err !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL done_flags: got stall=%b req=%b rv=%b err=%b, want 0 0 %b 0",
               stall, mem_req, rdata_valid, err, !we);
    end
    if (!we) begin
      compared++;
      if (rdata_ext !== erd) begin
        mismatched++;
        $display("[TB] FAIL load_data: sel=%0d addr=%h raw=%h got %h, want %h",
                 ls, a, raw, rdata_ext, erd);
      end
    end
    @(posedge clk); #1;
    req_valid = 1'b0; mem_ack = 1'b0;
    @(negedge clk);
    compared++;
    if (stall !== 1'b0 || mem_req !== 1'b0 || rdata_valid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL idle_after: got stall=%b req=%b rv=%b, want all 0",
               stall, mem_req, rdata_valid);
    end
  endtask

  // Outputs must all be zero while reset is held
  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; byteen = 4'h0; addr = 32'h0;
    wdata = 32'h0; ld_sel = LD_W; mem_ack = 1'b0; mem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    compared++;
    if (stall !== 1'b0 || rdata_valid !== 1'b0 || rdata_ext !== 32'h0 || err !== 1'b0 ||
        mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'h0 || mem_byteen !== 4'h0 ||
        mem_wdata !== 32'h0) begin
      mismatched++;
      $display("[TB] FAIL reset_values: got stall=%b rv=%b rd=%h err=%b req=%b we=%b addr=%h be=%b wd=%h, want all 0",
               stall, rdata_valid, rdata_ext, err, mem_req, mem_we, mem_addr, mem_byteen, mem_wdata);
    end
    reset = 1'b0;
  endtask

  // Word store with single-cycle ack
  task automatic test_store_word();
    do_txn(1'b1, 4'hF, 32'h10, 32'h12345678, LD_W, 1, 32'h0, 1'b0);
    compared++;
    if (obs_addr !== 32'h10 || obs_byteen !== 4'hF || obs_wdata !== 32'h12345678 || obs_stall_cnt != 2) begin
      mismatched++;
      $display("[TB] FAIL sw_fields: got addr=%h be=%b wd=%h stall=%0d, want 00000010 1111 12345678 2",
               obs_addr, obs_byteen, obs_wdata, obs_stall_cnt);
    end
  endtask

  // Byte store is replicated into all four lanes
  task automatic test_store_byte();
    do_txn(1'b1, 4'b1000, 32'h13, 32'h000000AB, LD_W, 1, 32'h0, 1'b1);
    compared++;
    if (obs_byteen !== 4'b1000 || obs_wdata !== 32'hABABABAB || obs_addr !== 32'h10) begin
      mismatched++;
      $display("[TB] FAIL sb_fields: got be=%b wd=%h addr=%h, want 1000 abababab 00000010",
               obs_byteen, obs_wdata, obs_addr);
    end
  endtask

  // Signed and unsigned byte loads from the same word
  task automatic test_load_byte();
    do_txn(1'b0, 4'h0, 32'h22, 32'h0, LD_B, 2, 32'h80FF7F00, 1'b0);
    compared++;
    if (obs_rdata !== 32'hFFFFFFFF) begin
      mismatched++;
      $display("[TB] FAIL lb_value: got %h, want ffffffff", obs_rdata);
    end
    do_txn(1'b0, 4'h0, 32'h22, 32'h0, LD_BU, 1, 32'h80FF7F00, 1'b0);
    compared++;
    if (obs_rdata !== 32'h000000FF) begin
      mismatched++;
      $display("[TB] FAIL lbu_value: got %h, want 000000ff", obs_rdata);
    end
  endtask

  // Upper signed half with a long ack delay
  task automatic test_load_half();
    do_txn(1'b0, 4'h5, 32'h2, 32'h0, LD_H, 5, 32'h80017FFF, 1'b0);
    compared++;
    if (obs_rdata !== 32'hFFFF8001 || obs_stall_cnt != 6) begin
      mismatched++;
      $display("[TB] FAIL lh_value: got %h stall=%0d, want ffff8001 stall=6", obs_rdata, obs_stall_cnt);
    end
  endtask

  // Zero-enable store and stray acks in IDLE must do nothing
  task automatic test_noop_store();
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      req_valid = 1'b1; req_we = 1'b1; byteen = 4'h0; addr = $urandom; wdata = $urandom;
      mem_ack = c[0];
      @(negedge clk);
      compared++;
      if (stall !== 1'b0 || mem_req !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL noop_store: cycle %0d got stall=%b req=%b, want 0 0", c, stall, mem_req);
      end
    end
    @(posedge clk); #1;
    req_valid = 1'b0; mem_ack = 1'b1;
    @(negedge clk);
    compared++;
    if (stall !== 1'b0 || mem_req !== 1'b0 || rdata_valid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL idle_ack: got stall=%b req=%b rv=%b, want 0 0 0", stall, mem_req, rdata_valid);
    end
    @(posedge clk); #1;
    mem_ack = 1'b0;
  endtask

  // Asynchronous reset while waiting for ack, then a clean access
  task automatic test_reset_mid_req();
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b0; byteen = 4'h0; addr = 32'h44; ld_sel = LD_W; mem_ack = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    compared++;
    if (mem_req !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL pre_reset_req: got %b, want 1", mem_req);
    end
    #1;
    reset = 1'b1; req_valid = 1'b0;
    #1;
    compared++;
    if (mem_req !== 1'b0 || stall !== 1'b0 || rdata_valid !== 1'b0 || err !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL async_reset: got req=%b stall=%b rv=%b err=%b, want 0 0 0 0",
               mem_req, stall, rdata_valid, err);
    end
    @(negedge clk); #1;
    reset = 1'b0;
    do_txn(1'b0, 4'h0, 32'h47, 32'h0, LD_BU, 1, 32'hC3000000, 1'b0);
    compared++;
    if (obs_rdata !== 32'h000000C3 || obs_addr !== 32'h44) begin
      mismatched++;
      $display("[TB] FAIL post_reset_txn: got rd=%h addr=%h, want 000000c3 00000044", obs_rdata, obs_addr);
    end
  endtask

  // Randomized mix of loads and stores with random ack delays
  task automatic test_random();
    logic        we;
    logic [3:0]  be;
    logic [2:0]  ls;
    logic [3:0]  be_tab [8] = '{4'hF, 4'h3, 4'hC, 4'h1, 4'h2, 4'h4, 4'h8, 4'h0};
    for (int n = 0; n < 40; n++) begin
      we = 1'($urandom_range(1));
      be = be_tab[$urandom_range(7)];
      if (be == 4'h0) be = 4'($urandom_range(15));
      if (we && be == 4'h0) be = 4'hF;
      ls = 3'($urandom_range(4));
      do_txn(we, be, $urandom, $urandom, ls, $urandom_range(1, 4), $urandom, 1'($urandom_range(1)));
    end
  endtask

`ifdef DM_TIMEOUT_EN
  // A load with no ack is aborted after 255 REQ cycles
  task automatic test_timeout();
    int req_cycles;
    bit got;
    req_cycles = 0;
    got = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b0; byteen = 4'h0; addr = 32'h80; ld_sel = LD_W; mem_ack = 1'b0;
    @(negedge clk);
    for (int c = 0; c < 300 && !got; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (err) got = 1'b1;
      else if (mem_req) req_cycles++;
    end
    compared++;
    if (!got || req_cycles != 255 || rdata_valid !== 1'b1 || rdata_ext !== 32'h0 || stall !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL timeout: got err_seen=%b req_cycles=%0d rv=%b rd=%h stall=%b, want 1 255 1 0 0",
               got, req_cycles, rdata_valid, rdata_ext, stall);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
  endtask
`endif

  initial begin
    $display("[TB] starting dm_access_ctrl bench");
    test_reset();
    test_store_word();
    test_store_byte();
    test_load_byte();
    test_load_half();
    test_noop_store();
    test_reset_mid_req();
    test_random();
`ifdef DM_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
